// File: rtl/spec_accumulator.sv
// spec_accumulator: sums a stream of power-spectrum frames bin by bin over a
// group of N frames and emits the per-bin totals during the last frame.
// Pipeline: the input is accepted and the RAM read is issued in p0. p1 holds
// the sample while the read returns, and the sum is formed there. The RAM
// write-back and the output register both take it on the next edge, so an
// accepted input is written and reported 2 cycles after it is presented.
module spec_accumulator #(
  parameter int BINS  = 1024,
  parameter int IN_W  = 32,
  parameter int ACC_W = 40
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [IN_W-1:0]         power_i,
  input  logic                    power_valid_i,
  input  logic [$clog2(BINS)-1:0] index_i,
  input  logic [7:0]              acc_num_i,
  input  logic                    clear_i,
  output logic                    acc_valid_o,
  output logic [$clog2(BINS)-1:0] acc_index_o,
  output logic [ACC_W-1:0]        acc_data_o,
  output logic                    group_done_o,
  output logic                    seq_err_o
);

  localparam int IDX_W = $clog2(BINS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BINS - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  // Plain unsigned add; the accumulator is wide enough for 255 full-scale
  // frames, so no saturation is applied.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] base,
                                               input logic [IN_W-1:0]  pwr);
    return base + ACC_W'(pwr);
  endfunction

  state_t           state_q;
  logic [IDX_W-1:0] exp_q;
  logic [7:0]       frame_q;
  logic [7:0]       num_q;

  logic             idx_ok, start, accept, seq_err;
  logic [7:0]       num_eff, cur_frame, cur_num;
  logic             first, last;

  logic             vld_p1_q, first_p1_q, last_p1_q, done_p1_q;
  logic [IDX_W-1:0] idx_p1_q;
  logic [IN_W-1:0]  pwr_p1_q;

  logic [ACC_W-1:0] ram_q [BINS];
  logic [ACC_W-1:0] rd_q, fwd_data_q, rd_val, sum_d;
  logic             fwd_hit_q, we;

  // ---- p0: accept decision and frame bookkeeping for the incoming sample
  // Classify the incoming sample: in sequence, new group start, or sequence error.
  always_comb begin
    num_eff   = (acc_num_i == 8'd0) ? 8'd1 : acc_num_i;
    idx_ok    = (state_q == ACCUM) && (index_i == exp_q);
    start     = power_valid_i && !clear_i && !idx_ok && (index_i == '0);
    seq_err   = power_valid_i && !clear_i && (state_q == ACCUM) && !idx_ok;
    accept    = power_valid_i && !clear_i && (idx_ok || start);
    cur_frame = start ? 8'd0 : frame_q;
    cur_num   = start ? num_eff : num_q;
    first     = (cur_frame == 8'd0);
    last      = (cur_frame == 8'(cur_num - 8'd1));
  end

  // Group FSM: tracks expected index, frame number and the latched group size.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      exp_q   <= '0;
      frame_q <= 8'd0;
      num_q   <= 8'd0;
    end else if (clear_i) begin
      state_q <= IDLE;
      frame_q <= 8'd0;
    end else if (accept) begin
      if (start) num_q <= num_eff;
      exp_q <= index_i + 1'b1;
      if (index_i == IDX_LAST && last) begin
        state_q <= IDLE;
        frame_q <= 8'd0;
      end else begin
        state_q <= ACCUM;
        frame_q <= (index_i == IDX_LAST) ? 8'(cur_frame + 8'd1) : cur_frame;
      end
    end else if (seq_err) begin
      state_q <= IDLE;
      frame_q <= 8'd0;
    end
  end

  // ---- p1: sample waits for its RAM read
  // Control side of the p1 stage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p1_q   <= 1'b0;
      first_p1_q <= 1'b0;
      last_p1_q  <= 1'b0;
      done_p1_q  <= 1'b0;
    end else begin
      vld_p1_q   <= accept;
      first_p1_q <= first;
      last_p1_q  <= last;
      done_p1_q  <= last && (index_i == IDX_LAST);
    end
  end

  // Data side of the p1 stage.
  always_ff @(posedge clk_i) begin
    idx_p1_q <= index_i;
    pwr_p1_q <= power_i;
  end

  // A clear kills the sample sitting in p1 along with its write-back and output.
  assign we     = vld_p1_q && !clear_i;
  assign rd_val = fwd_hit_q ? fwd_data_q : rd_q;
  assign sum_d  = acc_add(first_p1_q ? '0 : rd_val, pwr_p1_q);

  // Accumulator RAM: one write port (p1 result), one registered read port (p0 index).
  always_ff @(posedge clk_i) begin
    if (we) ram_q[idx_p1_q] <= sum_d;
    rd_q       <= ram_q[index_i];
    fwd_data_q <= sum_d;
  end

  // Flag a read that lands on the address being written this edge, so the fresh value is used.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) fwd_hit_q <= 1'b0;
    else          fwd_hit_q <= we && (idx_p1_q == index_i);
  end

  // ---- p2: registered outputs, written on the same edge as the RAM write-back
  // Final-frame results, group completion and sequence-error pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_valid_o  <= 1'b0;
      acc_index_o  <= '0;
      acc_data_o   <= '0;
      group_done_o <= 1'b0;
      seq_err_o    <= 1'b0;
    end else begin
      acc_valid_o  <= we && last_p1_q;
      group_done_o <= we && done_p1_q;
      seq_err_o    <= seq_err;
      if (we && last_p1_q) begin
        acc_index_o <= idx_p1_q;
        acc_data_o  <= sum_d;
      end
    end
  end

endmodule

// File: tb/tb_spec_accumulator.sv
// tb_spec_accumulator: randomized scenarios for spec_accumulator, checked
// against a group/frame summing model kept in the bench.
`timescale 1ns/1ps
module tb_spec_accumulator;

  localparam int BINS  = 1024;
  localparam int IN_W  = 32;
  localparam int ACC_W = 40;
  localparam int IDX_W = 10;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [ACC_W-1:0] data;
    logic             done;
    logic [31:0]      cyc;
  } out_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IN_W-1:0]  power;
  logic             power_valid;
  logic [IDX_W-1:0] index;
  logic [7:0]       acc_num;
  logic             clear;
  logic             acc_valid_o;
  logic [IDX_W-1:0] acc_index_o;
  logic [ACC_W-1:0] acc_data_o;
  logic             group_done_o;
  logic             seq_err_o;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned cyc = 0;
  int seq_cnt = 0;
  out_t obs_q[$];
  out_t exp_q[$];

  // reference model state
  longint unsigned m_sum [BINS];
  bit m_active = 0;
  int m_exp = 0, m_frame = 0, m_num = 1, m_seq = 0;

  spec_accumulator #(.BINS(BINS), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .power_i(power), .power_valid_i(power_valid),
    .index_i(index), .acc_num_i(acc_num), .clear_i(clear),
    .acc_valid_o(acc_valid_o), .acc_index_o(acc_index_o), .acc_data_o(acc_data_o),
    .group_done_o(group_done_o), .seq_err_o(seq_err_o)
  );

  always #2.5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // capture everything the DUT reports, 1 ns after each rising edge
  always @(posedge clk) begin
    out_t o;
    #1;
    if (acc_valid_o || group_done_o) begin
      o.idx = acc_index_o; o.data = acc_data_o; o.done = group_done_o; o.cyc = cyc;
      obs_q.push_back(o);
    end
    if (seq_err_o) seq_cnt++;
  end

  // Present one cycle of input (called at a falling edge) and advance the model.
  // A sample presented in cycle c is expected on the outputs in cycle c+2.
  task automatic step(input bit v, input int idx, input logic [IN_W-1:0] pwr, input bit clr);
    out_t e;
    bit acc;
    power_valid = v; index = idx[IDX_W-1:0]; power = pwr; clear = clr;
    if (clr) begin
      // the sample presented last cycle is still in flight and gets dropped
      while (exp_q.size() > 0 && exp_q[$].cyc == 32'(cyc + 1)) void'(exp_q.pop_back());
      m_active = 0;
    end else if (v) begin
      acc = m_active && (idx == m_exp);
      if (!acc) begin
        if (m_active) m_seq++;
        m_active = 0;
        if (idx == 0) begin
          m_active = 1; acc = 1; m_frame = 0;
          m_num = (acc_num == 8'd0) ? 1 : int'(acc_num);
        end
      end
      if (acc) begin
        m_sum[idx] = ((m_frame == 0) ? 64'd0 : m_sum[idx]) + 64'(pwr);
        if (m_frame == m_num - 1) begin
          e.idx = idx[IDX_W-1:0]; e.data = m_sum[idx][ACC_W-1:0];
          e.done = (idx == BINS - 1); e.cyc = 32'(cyc + 2);
          exp_q.push_back(e);
        end
        m_exp = (idx + 1) % BINS;
        if (idx == BINS - 1) begin
          m_frame++;
          if (m_frame == m_num) m_active = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input int idx, input logic [IN_W-1:0] pwr, input int gap_pct);
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
      step(0, $urandom_range(0, BINS - 1), $urandom, 0);
    step(1, idx, pwr, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic start_test();
    idle(4);
    obs_q.delete(); exp_q.delete(); seq_cnt = 0; m_seq = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; power_valid = 1'b1; index = '0; power = 32'd5; clear = 1'b0; acc_num = 8'd1;
    repeat (3) @(negedge clk);
    n_cmp++; if (acc_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, expected 0", acc_valid_o); end
    n_cmp++; if (acc_index_o !== '0) begin n_err++; $display("FAIL reset_index: got %0d, expected 0", acc_index_o); end
    n_cmp++; if (acc_data_o !== '0) begin n_err++; $display("FAIL reset_data: got %0d, expected 0", acc_data_o); end
    n_cmp++; if (group_done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, expected 0", group_done_o); end
    n_cmp++; if (seq_err_o !== 1'b0) begin n_err++; $display("FAIL reset_seqerr: got %b, expected 0", seq_err_o); end
    rst_n = 1'b1; power_valid = 1'b0;
    obs_q.delete();
    idle(6);
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL reset_quiet: got %0d outputs, expected 0", obs_q.size()); end
  endtask

  // acc_num=4, power=index, 4 contiguous frames
  task automatic test_basic();
    start_test();
    acc_num = 8'd4;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < BINS; i++) send(i, 32'(i), 0);
    idle(4);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL basic_out[%0d]: got idx=%0d data=%0d done=%0b cyc=%0d, expected idx=%0d data=%0d done=%0b cyc=%0d",
                 i, obs_q[i].idx, obs_q[i].data, obs_q[i].done, obs_q[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].done, exp_q[i].cyc);
      end
    end
  endtask

  // acc_num=0 behaves as a single-frame group
  task automatic test_n0();
    int dones;
    start_test();
    acc_num = 8'd0;
    for (int i = 0; i < BINS; i++) send(i, 32'd7, 20);
    idle(4);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL n0_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size()); end
    dones = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (obs_q[i].done) dones++;
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL n0_out[%0d]: got idx=%0d data=%0d done=%0b cyc=%0d, expected idx=%0d data=%0d done=%0b cyc=%0d",
                 i, obs_q[i].idx, obs_q[i].data, obs_q[i].done, obs_q[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].done, exp_q[i].cyc);
      end
    end
    n_cmp++; if (dones != 1) begin n_err++; $display("FAIL n0_done_count: got %0d, expected 1", dones); end
  endtask

  // index jump aborts the group; a clean group afterwards sums correctly
  task automatic test_seq_err();
    start_test();
    acc_num = 8'd2;
    for (int i = 0; i < 10; i++) send(i, $urandom, 0);
    send(12, $urandom, 0);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < BINS; i++) send(i, $urandom, 20);
    idle(4);
    n_cmp++; if (seq_cnt != m_seq) begin n_err++; $display("FAIL seq_err_pulses: got %0d, expected %0d", seq_cnt, m_seq); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL seq_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL seq_out[%0d]: got idx=%0d data=%0d done=%0b cyc=%0d, expected idx=%0d data=%0d done=%0b cyc=%0d",
                 i, obs_q[i].idx, obs_q[i].data, obs_q[i].done, obs_q[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].done, exp_q[i].cyc);
      end
    end
  endtask

  // full-scale input over 3 frames must not wrap
  task automatic test_max();
    start_test();
    acc_num = 8'd3;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < BINS; i++) send(i, '1, 0);
    idle(4);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL max_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL max_out[%0d]: got idx=%0d data=%0d done=%0b cyc=%0d, expected idx=%0d data=%0d done=%0b cyc=%0d",
                 i, obs_q[i].idx, obs_q[i].data, obs_q[i].done, obs_q[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].done, exp_q[i].cyc);
      end
    end
  endtask

  // clear on frame 1 index 500, then acc_num changed mid-group
  task automatic test_clear();
    start_test();
    acc_num = 8'd2;
    for (int i = 0; i < BINS; i++) send(i, $urandom, 0);
    for (int i = 0; i < 500; i++) send(i, $urandom, 0);
    step(1, 500, $urandom, 1);
    for (int i = 501; i < BINS; i++) send(i, $urandom, 0);
    acc_num = 8'd2;
    for (int i = 0; i < BINS; i++) begin
      if (i == 100) acc_num = 8'd5;
      send(i, $urandom, 10);
    end
    for (int i = 0; i < BINS; i++) send(i, $urandom, 10);
    idle(4);
    n_cmp++; if (seq_cnt != 0) begin n_err++; $display("FAIL clear_seqerr: got %0d pulses, expected 0", seq_cnt); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL clear_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL clear_out[%0d]: got idx=%0d data=%0d done=%0b cyc=%0d, expected idx=%0d data=%0d done=%0b cyc=%0d",
                 i, obs_q[i].idx, obs_q[i].data, obs_q[i].done, obs_q[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].done, exp_q[i].cyc);
      end
    end
  endtask

  // 5 ns reset pulse in the middle of a reporting frame with random gaps
  task automatic test_reset_mid();
    int unsigned r;
    start_test();
    acc_num = 8'd1;
    for (int i = 0; i < 300; i++) send(i, $urandom, 30);
    r = cyc;
    rst_n = 1'b0; power_valid = 1'b0; clear = 1'b0;
    #1;
    n_cmp++; if (acc_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b, expected 0", acc_valid_o); end
    n_cmp++; if (acc_index_o !== '0) begin n_err++; $display("FAIL rstmid_index: got %0d, expected 0", acc_index_o); end
    n_cmp++; if (acc_data_o !== '0) begin n_err++; $display("FAIL rstmid_data: got %0d, expected 0", acc_data_o); end
    n_cmp++; if (group_done_o !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b, expected 0", group_done_o); end
    @(negedge clk);
    rst_n = 1'b1;
    while (exp_q.size() > 0 && exp_q[$].cyc > r) void'(exp_q.pop_back());
    m_active = 0;
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rstmid_pre_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rstmid_pre[%0d]: got idx=%0d data=%0d done=%0b cyc=%0d, expected idx=%0d data=%0d done=%0b cyc=%0d",
                 i, obs_q[i].idx, obs_q[i].data, obs_q[i].done, obs_q[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].done, exp_q[i].cyc);
      end
    end
    obs_q.delete(); exp_q.delete();
    for (int i = 300; i < BINS; i++) send(i, $urandom, 30);
    acc_num = 8'd2;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < BINS; i++) send(i, $urandom, 30);
    idle(4);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rstmid_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rstmid_out[%0d]: got idx=%0d data=%0d done=%0b cyc=%0d, expected idx=%0d data=%0d done=%0b cyc=%0d",
                 i, obs_q[i].idx, obs_q[i].data, obs_q[i].done, obs_q[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].done, exp_q[i].cyc);
      end
    end
  endtask

  // back-to-back groups of random size with random data and gaps
  task automatic test_back_to_back();
    start_test();
    for (int g = 0; g < 2; g++) begin
      acc_num = 8'($urandom_range(0, 3));
      for (int f = 0; f < ((acc_num == 8'd0) ? 1 : int'(acc_num)); f++)
        for (int i = 0; i < BINS; i++) send(i, $urandom, 25);
    end
    idle(4);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL b2b_out[%0d]: got idx=%0d data=%0d done=%0b cyc=%0d, expected idx=%0d data=%0d done=%0b cyc=%0d",
                 i, obs_q[i].idx, obs_q[i].data, obs_q[i].done, obs_q[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].done, exp_q[i].cyc);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; power_valid = 1'b0; index = '0; power = '0; acc_num = 8'd1; clear = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_n0();
    test_seq_err();
    test_max();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spec_accumulator.md
SPEC_ACCUMULATOR -- requirements
Module: spec_accumulator

Interface
REQ-001 SHALL have parameter BINS, default 1024, meaning power-spectrum bins per frame (power of two).
REQ-002 SHALL have parameter IN_W, default 32, meaning width of input power word (unsigned).
REQ-003 SHALL have parameter ACC_W, default 40, meaning width of accumulated output (IN_W+8).
REQ-004 SHALL have port clk_i, input, 1, meaning the single 200 MHz clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port power_i, input, IN_W, meaning power-spectrum value from the power-spectrum calculator.
REQ-007 SHALL have port power_valid_i, input, 1, meaning power_i/index_i valid this cycle.
REQ-008 SHALL have port index_i, input, log2(BINS), meaning bin index of power_i.
REQ-009 SHALL have port acc_num_i, input, 8, meaning frames per group (0 treated as 1), taken from user register.
REQ-010 SHALL have port clear_i, input, 1, meaning synchronous abort of current group.
REQ-011 SHALL have port acc_valid_o, input-derived output, 1, meaning acc_data_o/acc_index_o valid.
REQ-012 SHALL have port acc_index_o, output, log2(BINS), meaning bin index of acc_data_o.
REQ-013 SHALL have port acc_data_o, output, ACC_W, meaning summed power of that bin over the group.
REQ-014 SHALL have port group_done_o, output, 1, meaning one-cycle pulse with last bin of a group.
REQ-015 SHALL have port seq_err_o, output, 1, meaning one-cycle pulse on index sequence violation.

Function
REQ-016 SHALL hold a BINS x ACC_W accumulator RAM (inferred block RAM, one read and one write port).
REQ-017 SHALL implement FSM states IDLE, ACCUM; IDLE -> ACCUM on power_valid_i with index_i==0; ACCUM -> IDLE on group completion, clear_i or sequence error.
REQ-018 SHALL latch acc_num_i (0 mapped to 1) on the IDLE->ACCUM transition; changes during ACCUM ignored until next group.
REQ-019 In IDLE, valid samples with index_i!=0 SHALL be dropped silently (no error).
REQ-020 In ACCUM, expected index SHALL increment by 1 per accepted sample and wrap BINS-1 -> 0; frame counter increments on accepted index BINS-1.
REQ-021 Valid sample with index_i != expected in ACCUM SHALL pulse seq_err_o, abort group, return to IDLE; if that sample has index 0 it SHALL start a new group in the same cycle.
REQ-022 Frame 0 of a group SHALL write power_i (zero-extended) to RAM, overwriting previous contents; no explicit RAM clear.
REQ-023 Frames 1..N-2 SHALL write RAM[index]+power_i; no output.
REQ-024 Final frame (N-1) SHALL output RAM[index]+power_i on acc_data_o with acc_valid_o=1, acc_index_o=index; for N=1 output is power_i.
REQ-025 Latency SHALL be exactly 2 cycles from accepted input to RAM write and to acc_valid_o; throughput one sample per cycle, gaps in power_valid_i allowed.
REQ-026 Addition SHALL be unsigned ACC_W-bit; ACC_W>=IN_W+8 guarantees no overflow for N<=255; no saturation logic.
REQ-027 group_done_o SHALL assert in the same cycle as acc_valid_o for acc_index_o==BINS-1 of the final frame.
REQ-028 clear_i SHALL take priority over a simultaneous input sample: sample discarded, FSM to IDLE, in-flight pipeline outputs (<=2) suppressed.
REQ-029 Read-write address collision SHALL not occur given sequential indices; pipeline SHALL still forward the in-flight write value when read address equals a pending write address.

Reset
REQ-030 rst_n_i low SHALL asynchronously force FSM IDLE, counters 0, acc_valid_o=0, acc_index_o=0, acc_data_o=0, group_done_o=0, seq_err_o=0.
REQ-031 RAM contents SHALL be don't-care after reset; frame 0 overwrite makes them irrelevant.
REQ-032 Reset mid-group SHALL discard the group; next output only after a full new group.

Verification
REQ-033 BINS=1024, acc_num_i=4, power_i=bin index, 4 contiguous frames -> 1024 outputs, acc_data_o=4*index, group_done_o at index 1023, first output 2 cycles after frame 3 index 0.
REQ-034 acc_num_i=0, power_i=7 one frame -> acc_data_o=7 every bin, group_done_o once.
REQ-035 acc_num_i=2, index 0..9 then index 12 -> seq_err_o pulse, no outputs; following clean 2 frames produce correct sums.
REQ-036 acc_num_i=3, power_i=2^32-1 all bins, 3 frames -> acc_data_o=3*(2^32-1), no wrap.
REQ-037 clear_i asserted on frame 1 index 500 of N=2 -> no outputs; change acc_num_i mid-group from 2 to 5 -> old value used.
REQ-038 rst_n_i pulsed low 5 ns mid-frame with power_valid_i random gaps -> outputs 0 immediately, resume correctly on next index-0 group.
